// File: rtl/fu_pkg.sv
// Shared constants for the dual functional-unit pipeline: opcodes, shifter
// modes and flag-bit positions.
package fu_pkg;
  localparam int OPC_W = 5;

  localparam logic [OPC_W-1:0] OP_PASS = 5'b00000;
  localparam logic [OPC_W-1:0] OP_ADD  = 5'b00001;
  localparam logic [OPC_W-1:0] OP_SUB  = 5'b00010;
  localparam logic [OPC_W-1:0] OP_AND  = 5'b00011;
  localparam logic [OPC_W-1:0] OP_OR   = 5'b00100;
  localparam logic [OPC_W-1:0] OP_XOR  = 5'b00101;
  localparam logic [OPC_W-1:0] OP_NOT  = 5'b00110;
  localparam logic [OPC_W-1:0] OP_NEG  = 5'b00111;
  localparam logic [OPC_W-1:0] OP_INC  = 5'b01000;
  localparam logic [OPC_W-1:0] OP_DEC  = 5'b01001;
  localparam logic [OPC_W-1:0] OP_SLT  = 5'b01010;
  localparam logic [OPC_W-1:0] OP_SLTU = 5'b01011;
  localparam logic [OPC_W-1:0] OP_MIN  = 5'b01100;
  localparam logic [OPC_W-1:0] OP_MAX  = 5'b01101;

  localparam logic [1:0] SHF_LSL = 2'b00;
  localparam logic [1:0] SHF_LSR = 2'b01;
  localparam logic [1:0] SHF_ASR = 2'b10;
  localparam logic [1:0] SHF_ROR = 2'b11;

  localparam int FLG_Z = 0;
  localparam int FLG_N = 1;
  localparam int FLG_R = 2;
  localparam int FLG_O = 3;
  localparam int FLG_W = 4;
endpackage

// File: rtl/fu_alu.sv
// Combinational ALU: opcode, X, Y -> result plus carry/borrow (R) and signed
// overflow (O). One shared adder serves ADD/SUB/INC/DEC/NEG.
module fu_alu
  import fu_pkg::*;
#(
  parameter int DSIZE  = 64,
  parameter int OPSIZE = 5
) (
  input  logic [OPSIZE-1:0] op,
  input  logic [DSIZE-1:0]  x,
  input  logic [DSIZE-1:0]  y,
  output logic [DSIZE-1:0]  res,
  output logic              r,
  output logic              o
);
  logic [DSIZE-1:0] ax, ay, ey;
  logic             sub;
  logic [DSIZE:0]   sum;
  logic             ovf, slt;

  always_comb begin
    ax  = x;
    ay  = y;
    sub = 1'b0;
    case (op)
      OPSIZE'(OP_SUB): sub = 1'b1;
      OPSIZE'(OP_INC): ay = DSIZE'(1);
      OPSIZE'(OP_DEC): begin ay = DSIZE'(1); sub = 1'b1; end
      OPSIZE'(OP_NEG): begin ax = '0; ay = x; sub = 1'b1; end
      default: ;
    endcase
  end

  // Borrow falls out of the zero-extended subtract as the top bit (X<Y unsigned).
  assign sum = sub ? ({1'b0, ax} - {1'b0, ay}) : ({1'b0, ax} + {1'b0, ay});
  assign ey  = sub ? ~ay : ay;
  assign ovf = (ax[DSIZE-1] == ey[DSIZE-1]) && (sum[DSIZE-1] != ax[DSIZE-1]);
  assign slt = $signed(x) < $signed(y);

  always_comb begin
    res = '0;
    r   = 1'b0;
    o   = 1'b0;
    case (op)
      OPSIZE'(OP_PASS): res = x;
      OPSIZE'(OP_ADD), OPSIZE'(OP_SUB), OPSIZE'(OP_INC),
      OPSIZE'(OP_DEC), OPSIZE'(OP_NEG): begin
        res = sum[DSIZE-1:0];
        r   = sum[DSIZE];
        o   = ovf;
      end
      OPSIZE'(OP_AND):  res = x & y;
      OPSIZE'(OP_OR):   res = x | y;
      OPSIZE'(OP_XOR):  res = x ^ y;
      OPSIZE'(OP_NOT):  res = ~x;
      OPSIZE'(OP_SLT):  res = DSIZE'(slt);
      OPSIZE'(OP_SLTU): res = DSIZE'(x < y);
      OPSIZE'(OP_MIN):  res = slt ? x : y;
      OPSIZE'(OP_MAX):  res = slt ? y : x;
      default: ;
    endcase
  end
endmodule

// File: rtl/fu_dual_pipe.sv
// Two-stage dual-ALU pipeline: stage 0 registers the selected ALU result,
// stage 1 barrel-shifts it and registers OUT with Z/N/R/O flags.
module fu_dual_pipe
  import fu_pkg::*;
#(
  parameter int DSIZE  = 64,
  parameter int OPSIZE = 5,
  parameter int ASIZE  = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DSIZE-1:0]  a,
  input  logic [DSIZE-1:0]  b,
  input  logic [DSIZE-1:0]  c,
  input  logic [DSIZE-1:0]  d,
  input  logic [OPSIZE-1:0] op1,
  input  logic [OPSIZE-1:0] op2,
  input  logic              sel,
  input  logic [1:0]        shf_mode,
  input  logic [ASIZE-1:0]  shf_amt,
  output logic [DSIZE-1:0]  out,
  output logic              z,
  output logic              n,
  output logic              r,
  output logic              o,
  output logic              out_valid
);
  localparam int NUM_UNITS = 2;
  localparam int STAGES    = 1;

  typedef struct packed {
    logic [DSIZE-1:0] res;
    logic             r;
    logic             o;
    logic [1:0]       mode;
    logic [ASIZE-1:0] amt;
  } s1_t;

  logic [NUM_UNITS-1:0][DSIZE-1:0]  ux, uy, ures;
  logic [NUM_UNITS-1:0][OPSIZE-1:0] uop;
  logic [NUM_UNITS-1:0]             ur, uo;
  logic [STAGES:0]                  vld_pipe;
  s1_t                              s1_q;
  logic [2*DSIZE-1:0]               ror_w;
  logic [DSIZE-1:0]                 shf, out_q;
  logic [FLG_W-1:0]                 flg_d, flg_q;

  assign ux  = {c, a};
  assign uy  = {d, b};
  assign uop = {op2, op1};

  for (genvar u = 0; u < NUM_UNITS; u++) begin : g_unit
    fu_alu #(.DSIZE(DSIZE), .OPSIZE(OPSIZE)) u_alu (
      .op (uop[u]),
      .x  (ux[u]),
      .y  (uy[u]),
      .res(ures[u]),
      .r  (ur[u]),
      .o  (uo[u])
    );
  end

  // vld_pipe[0]: stage-0 register holds a live vector; vld_pipe[STAGES]: OUT is fresh.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vld_pipe <= '0;
    else        vld_pipe <= {vld_pipe[STAGES-1:0], in_valid};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) s1_q <= '0;
    else if (in_valid)
      s1_q <= '{res: ures[sel], r: ur[sel], o: uo[sel], mode: shf_mode, amt: shf_amt};
  end

  // Rotate via a doubled word so amount 0 needs no special case.
  always_comb begin
    ror_w = {s1_q.res, s1_q.res} >> s1_q.amt;
    shf   = ror_w[DSIZE-1:0];
    case (s1_q.mode)
      SHF_LSL: shf = s1_q.res << s1_q.amt;
      SHF_LSR: shf = s1_q.res >> s1_q.amt;
      SHF_ASR: shf = $signed(s1_q.res) >>> s1_q.amt;
      default: ;
    endcase
  end

  always_comb begin
    flg_d        = '0;
    flg_d[FLG_Z] = (shf == '0);
    flg_d[FLG_N] = shf[DSIZE-1];
    flg_d[FLG_R] = s1_q.r;
    flg_d[FLG_O] = s1_q.o;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q <= '0;
      flg_q <= '0;
    end else if (vld_pipe[0]) begin
      out_q <= shf;
      flg_q <= flg_d;
    end
  end

  assign out       = out_q;
  assign z         = flg_q[FLG_Z];
  assign n         = flg_q[FLG_N];
  assign r         = flg_q[FLG_R];
  assign o         = flg_q[FLG_O];
  assign out_valid = vld_pipe[STAGES];
endmodule

// File: tb/tb_fu_dual_pipe.sv
// Directed bench for fu_dual_pipe: table of single vectors with hand-computed
// results, plus reset-in-flight and streaming sequences.
module tb_fu_dual_pipe;
  localparam logic [4:0] PASS = 5'd0,  ADD = 5'd1,  SUB = 5'd2,  AND_ = 5'd3,
                         OR_  = 5'd4,  XOR_ = 5'd5, NOT_ = 5'd6, NEG = 5'd7,
                         INC  = 5'd8,  DEC = 5'd9,  SLT = 5'd10, SLTU = 5'd11,
                         MIN  = 5'd12, MAX = 5'd13, BAD = 5'd31;
  localparam logic [1:0] LSL = 2'd0, LSR = 2'd1, ASR = 2'd2, ROR = 2'd3;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] MSB  = 64'h8000_0000_0000_0000;

  logic        clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, sel = 1'b0;
  logic [63:0] a = '0, b = '0, c = '0, d = '0, out;
  logic [4:0]  op1 = '0, op2 = '0;
  logic [1:0]  shf_mode = '0;
  logic [5:0]  shf_amt = '0;
  logic        z, n, r, o, out_valid;
  int          total = 0, bad = 0;

  fu_dual_pipe dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .a(a), .b(b), .c(c), .d(d), .op1(op1), .op2(op2), .sel(sel),
    .shf_mode(shf_mode), .shf_amt(shf_amt),
    .out(out), .z(z), .n(n), .r(r), .o(o), .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] a, b, c, d;
    logic [4:0]  op1, op2;
    logic        sel;
    logic [1:0]  mode;
    logic [5:0]  amt;
    logic [63:0] x_out;
    logic [3:0]  x_flg; // {O,R,N,Z}
  } vec_t;

  vec_t vq[$];

  // Unit-1 vector; unit 2 carries a distinct result so a wrong select shows up.
  function automatic vec_t u1(logic [4:0] op, logic [63:0] x, logic [63:0] y,
                              logic [1:0] m, logic [5:0] s, logic [63:0] e, logic [3:0] f);
    vec_t v;
    v = '{a: x, b: y, c: 64'hAAAA, d: 64'h5555, op1: op, op2: ADD, sel: 1'b0,
          mode: m, amt: s, x_out: e, x_flg: f};
    return v;
  endfunction

  function automatic vec_t u2(logic [4:0] op, logic [63:0] x, logic [63:0] y,
                              logic [1:0] m, logic [5:0] s, logic [63:0] e, logic [3:0] f);
    vec_t v;
    v = '{a: 64'h1234, b: 64'h1, c: x, d: y, op1: ADD, op2: op, sel: 1'b1,
          mode: m, amt: s, x_out: e, x_flg: f};
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v, input logic vld);
    a = v.a; b = v.b; c = v.c; d = v.d; op1 = v.op1; op2 = v.op2;
    sel = v.sel; shf_mode = v.mode; shf_amt = v.amt; in_valid = vld;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    @(negedge clk);
    drive(v, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk($sformatf("v%0d early_valid", idx), 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    chk($sformatf("v%0d valid", idx), 64'(out_valid), 64'd1);
    chk($sformatf("v%0d out", idx), out, v.x_out);
    chk($sformatf("v%0d flags_ORNZ", idx), 64'({o, r, n, z}), 64'(v.x_flg));
  endtask

  vec_t sv[4];
  logic       s_in[7];
  int         s_idx[7];
  logic       s_vld[7];
  logic [63:0] s_out[7];

  initial begin
    // Reset asserted from time 0.
    #1;
    chk("rst out", out, 64'd0);
    chk("rst valid", 64'(out_valid), 64'd0);
    chk("rst flags", 64'({o, r, n, z}), 64'd0);
    @(negedge clk); rst_n = 1'b1;

    vq.push_back(u1(ADD,  64'h7FFF_FFFF_FFFF_FFFF, 64'd1, LSL, 6'd0, MSB, 4'b1010));
    vq.push_back(u2(SUB,  64'd5, 64'd5, LSL, 6'd0, 64'd0, 4'b0001));
    vq.push_back(u2(SUB,  64'd3, 64'd5, LSL, 6'd0, 64'hFFFF_FFFF_FFFF_FFFE, 4'b0110));
    vq.push_back(u1(PASS, 64'h8000_0000_0000_0001, 64'd0, ASR, 6'd4, 64'hF800_0000_0000_0000, 4'b0010));
    vq.push_back(u1(PASS, 64'h8000_0000_0000_0001, 64'd0, ROR, 6'd1, 64'hC000_0000_0000_0000, 4'b0010));
    vq.push_back(u1(PASS, 64'h8000_0000_0000_0001, 64'd0, LSL, 6'd63, MSB, 4'b0010));
    vq.push_back(u1(BAD,  64'hFFFF, 64'hFFFF, LSL, 6'd0, 64'd0, 4'b0001));
    vq.push_back(u1(NEG,  MSB, 64'd0, LSL, 6'd0, MSB, 4'b1110));
    vq.push_back(u1(DEC,  64'd0, 64'd0, LSL, 6'd0, ONES, 4'b0110));
    vq.push_back(u1(INC,  ONES, 64'd0, LSL, 6'd0, 64'd0, 4'b0101));
    vq.push_back(u1(SLT,  ONES, 64'd1, LSL, 6'd0, 64'd1, 4'b0000));
    vq.push_back(u1(SLTU, ONES, 64'd1, LSL, 6'd0, 64'd0, 4'b0001));
    vq.push_back(u2(MIN,  ONES, 64'd2, LSL, 6'd0, ONES, 4'b0010));
    vq.push_back(u1(PASS, 64'hF0, 64'd0, LSR, 6'd4, 64'h0F, 4'b0000));
    vq.push_back(u1(NOT_, 64'd0, 64'd0, LSL, 6'd0, ONES, 4'b0010));
    vq.push_back(u1(AND_, 64'hF0, 64'h3C, LSL, 6'd0, 64'h30, 4'b0000));
    vq.push_back(u1(OR_,  64'hF0, 64'h0F, LSL, 6'd0, 64'hFF, 4'b0000));
    vq.push_back(u1(ADD,  ONES, 64'd2, LSL, 6'd0, 64'd1, 4'b0100));
    vq.push_back(u1(SUB,  MSB, 64'd1, LSL, 6'd0, 64'h7FFF_FFFF_FFFF_FFFF, 4'b1000));
    vq.push_back(u1(PASS, 64'h1234, 64'd0, ROR, 6'd0, 64'h1234, 4'b0000));
    vq.push_back(u2(MAX,  ONES, 64'd2, LSL, 6'd4, 64'h20, 4'b0000));
    vq.push_back(u1(XOR_, 64'hA5, 64'hFF, ASR, 6'd0, 64'h5A, 4'b0000));
    vq.push_back(u1(PASS, MSB, 64'd0, LSR, 6'd63, 64'd1, 4'b0000));
    // R/O come from the pre-shift result, Z/N from the shifted one.
    vq.push_back(u1(ADD,  64'h7FFF_FFFF_FFFF_FFFF, 64'd1, LSR, 6'd63, 64'd1, 4'b1000));

    foreach (vq[i]) run_vec(vq[i], i);

    // Reset with both stages occupied: outputs clear without a clock edge.
    @(negedge clk); drive(u1(ADD, 64'd1, 64'd2, LSL, 6'd0, 64'd3, 4'b0000), 1'b1);
    @(posedge clk); #1;
    @(negedge clk); drive(u1(PASS, 64'h77, 64'd0, LSL, 6'd0, 64'h77, 4'b0000), 1'b1);
    @(posedge clk); #1;
    chk("pre-rst valid", 64'(out_valid), 64'd1);
    chk("pre-rst out", out, 64'd3);
    #2;
    rst_n = 1'b0; in_valid = 1'b0;
    #1;
    chk("mid-rst out", out, 64'd0);
    chk("mid-rst valid", 64'(out_valid), 64'd0);
    chk("mid-rst flags", 64'({o, r, n, z}), 64'd0);
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk($sformatf("post-rst idle%0d valid", i), 64'(out_valid), 64'd0);
    end
    run_vec(u1(SUB, 64'd9, 64'd4, LSL, 6'd0, 64'd5, 4'b0000), 100);

    // Streaming: three back-to-back vectors, a bubble, then a fourth.
    sv[0] = u1(ADD,  64'd1, 64'd2, LSL, 6'd0, 64'd3, 4'b0000);
    sv[1] = u1(SUB,  64'd9, 64'd4, LSL, 6'd0, 64'd5, 4'b0000);
    sv[2] = u1(XOR_, 64'hF0, 64'hFF, LSL, 6'd0, 64'h0F, 4'b0000);
    sv[3] = u2(MAX,  ONES, 64'd2, LSL, 6'd0, 64'd2, 4'b0000);
    s_in  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    s_idx = '{0, 1, 2, 0, 3, 0, 0};
    s_vld = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    s_out = '{64'd5, 64'd3, 64'd5, 64'h0F, 64'h0F, 64'd2, 64'd2};
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      drive(sv[s_idx[i]], s_in[i]);
      @(posedge clk); #1;
      chk($sformatf("stream%0d valid", i), 64'(out_valid), 64'(s_vld[i]));
      if (i > 0) chk($sformatf("stream%0d out", i), out, s_out[i]);
    end
    in_valid = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
